// File: rtl/game_tick_scheduler_if.sv
// game_tick_scheduler_if: phase handshake between the tick scheduler and the game-state modules
//   game_tick    scheduler -> game  1-cycle pulse at the start of an update sequence
//   phase_start  scheduler -> game  one-hot 1-cycle pulse on entry to phase k
//   busy         scheduler -> game  high while any phase is active
//   phase_done   game -> scheduler  bit k completes phase k
interface game_tick_scheduler_if;
    logic       game_tick;
    logic [3:0] phase_start;
    logic       busy;
    logic [3:0] phase_done;
    modport master (output game_tick, phase_start, busy, input phase_done);
    modport slave (input game_tick, phase_start, busy, output phase_done);
endinterface

// File: rtl/game_tick_scheduler.sv
// game_tick_scheduler: one game-update trigger per frame (or per debounced KEY press) sequenced into four phase enables
//   clk, rst                  system clock, synchronous active-high reset
//   SW                        0 = run on frame events, 1 = single-step on KEY
//   KEY                       active-low step button, asynchronous
//   current_pixel_x/y         VGA pixel position
//   tick_if                   game_tick / phase_start / busy out, phase_done in
//   frame_count               completed sequences, wrapping
//   overrun_count             triggers dropped while busy, saturating
//   timeout_flag              sticky, set when a phase advanced on timeout
module game_tick_scheduler #(
    parameter int H_LAST = 639,
    parameter int V_LAST = 479,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         SW,
    input  logic                         KEY,
    input  logic [9:0]                   current_pixel_x,
    input  logic [9:0]                   current_pixel_y,
    game_tick_scheduler_if.master        tick_if,
    output logic [15:0]                  frame_count,
    output logic [7:0]                   overrun_count,
    output logic                         timeout_flag
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    typedef enum logic [2:0] {IDLE, PH0, PH1, PH2, PH3} state_t;
    state_t state, state_n;
    logic key_s1, key_s2, key_stable, key_stable_d;
    logic sw_s1, sw_s2, mode_q;
    logic fpos_q, fpos_d;
    logic [DW-1:0] deb_cnt;
    logic [TW-1:0] ph_cnt;
    logic frame_evt, step_evt, trigger, tout, done_cur, adv;
    logic [3:0] start_n;
    assign frame_evt = fpos_q & ~fpos_d;
    assign step_evt = key_stable_d & ~key_stable;
    assign trigger = mode_q ? step_evt : frame_evt;
    assign tout = ph_cnt == TW'(TIMEOUT_CYCLES - 1);
    // Input conditioning: synchronizers, debounce, frame-position edge detect
    always_ff @(posedge clk) begin
        if (rst) begin
            key_s1 <= 1'b1;
            key_s2 <= 1'b1;
            key_stable <= 1'b1;
            key_stable_d <= 1'b1;
            sw_s1 <= 1'b0;
            sw_s2 <= 1'b0;
            mode_q <= 1'b0;
            fpos_q <= 1'b0;
            fpos_d <= 1'b0;
            deb_cnt <= '0;
        end else begin
            key_s1 <= KEY;
            key_s2 <= key_s1;
            key_stable_d <= key_stable;
            sw_s1 <= SW;
            sw_s2 <= sw_s1;
            fpos_q <= current_pixel_x == 10'(H_LAST) && current_pixel_y == 10'(V_LAST);
            fpos_d <= fpos_q;
            // Mode only follows SW between sequences so a running sequence keeps its source
            if (state == IDLE) mode_q <= sw_s2;
            // Counter runs only while the synced key disagrees with the accepted level; any bounce back restarts it
            if (key_s2 == key_stable) deb_cnt <= '0;
            else if (deb_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
                key_stable <= key_s2;
                deb_cnt <= '0;
            end else deb_cnt <= deb_cnt + 1'b1;
        end
    end
    always_comb begin
        state_n = state;
        start_n = 4'b0000;
        case (state)
            PH0: done_cur = tick_if.phase_done[0];
            PH1: done_cur = tick_if.phase_done[1];
            PH2: done_cur = tick_if.phase_done[2];
            PH3: done_cur = tick_if.phase_done[3];
            default: done_cur = 1'b0;
        endcase
        // A timeout advances the phase exactly like a done
        adv = state != IDLE && (done_cur || tout);
        case (state)
            IDLE: if (trigger) begin
                state_n = PH0;
                start_n = 4'b0001;
            end
            PH0: if (adv) begin
                state_n = PH1;
                start_n = 4'b0010;
            end
            PH1: if (adv) begin
                state_n = PH2;
                start_n = 4'b0100;
            end
            PH2: if (adv) begin
                state_n = PH3;
                start_n = 4'b1000;
            end
            PH3: if (adv) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ph_cnt <= '0;
            tick_if.game_tick <= 1'b0;
            tick_if.phase_start <= 4'b0000;
            tick_if.busy <= 1'b0;
            frame_count <= '0;
            overrun_count <= '0;
            timeout_flag <= 1'b0;
        end else begin
            state <= state_n;
            ph_cnt <= state_n != state ? '0 : ph_cnt + 1'b1;
            tick_if.game_tick <= state == IDLE && trigger;
            tick_if.phase_start <= start_n;
            tick_if.busy <= state_n != IDLE;
            if (state == PH3 && adv) frame_count <= frame_count + 1'b1;
            // Includes a trigger landing on the PH3 -> IDLE cycle
            if (trigger && state != IDLE && overrun_count != 8'hFF) overrun_count <= overrun_count + 1'b1;
            if (adv && !done_cur) timeout_flag <= 1'b1;
        end
    end
endmodule

// File: tb/tb_game_tick_scheduler.sv
// tb_game_tick_scheduler: randomized scoreboard bench for game_tick_scheduler against a timeline model
module tb_game_tick_scheduler;
    localparam int H_LAST = 639;
    localparam int V_LAST = 479;
    localparam int DEB = 4;
    localparam int TMO = 16;
    localparam int FRAME = 0;
    localparam int STEP = 1;
    typedef struct {
        int         c;
        logic       tk;
        logic [3:0] ps;
    } exp_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sw = 1'b0;
    logic key = 1'b1;
    logic [9:0] px = '0;
    logic [9:0] py = '0;
    logic [15:0] fc;
    logic [7:0] oc;
    logic tf;
    game_tick_scheduler_if gif();
    game_tick_scheduler #(
        .H_LAST(H_LAST),
        .V_LAST(V_LAST),
        .DEBOUNCE_CYCLES(DEB),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .SW(sw),
        .KEY(key),
        .current_pixel_x(px),
        .current_pixel_y(py),
        .tick_if(gif),
        .frame_count(fc),
        .overrun_count(oc),
        .timeout_flag(tf)
    );
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;
    int n_cmp = 0;
    int n_err = 0;
    bit mon_en = 1'b0;
    exp_t exp_q[$];
    bit busy_at[int];
    logic [3:0] done_at[int];
    logic [3:0] forbid_at[int];
    int be = -1;
    int model_mode = FRAME;
    int last_e[4];
    int dl[4];
    int m_frames = 0;
    int m_ovr = 0;
    int m_tf = 0;
    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, act, exp);
        end
    endtask
    task automatic rand_dl();
        int r;
        for (int k = 0; k < 4; k++) begin
            r = $urandom_range(0, 19);
            dl[k] = r < 14 ? r % 5 : r < 16 ? TMO - 1 : r < 17 ? -1 : r < 18 ? TMO - 2 : 7;
        end
    endtask
    // A trigger active during cycle t: dropped if the scheduler is busy then, else it
    // starts a sequence whose phase k lasts dl[k]+1 cycles (TMO cycles when no done comes).
    task automatic model_trigger(input int src, input int t);
        int e;
        int adv;
        exp_t x;
        if (src != model_mode) return;
        if (busy_at.exists(t)) begin
            if (m_ovr < 255) m_ovr++;
            return;
        end
        e = t + 1;
        for (int k = 0; k < 4; k++) begin
            if (dl[k] < 0 || dl[k] >= TMO) begin
                adv = e + TMO - 1;
                m_tf = 1;
            end else begin
                adv = e + dl[k];
                done_at[adv] = 4'(1 << k);
            end
            for (int c = e; c <= adv; c++) begin
                forbid_at[c] = 4'(1 << k);
                busy_at[c] = 1'b1;
            end
            x.c = e;
            x.tk = k == 0;
            x.ps = 4'(1 << k);
            exp_q.push_back(x);
            last_e[k] = e;
            e = adv + 1;
        end
        be = e - 1;
        m_frames++;
        rand_dl();
    endtask
    // Phase responder: done bits from the model schedule, random noise on every bit that cannot complete the current phase
    always @(negedge clk) begin : drv
        logic [3:0] f;
        logic [3:0] d;
        f = forbid_at.exists(cyc) ? forbid_at[cyc] : 4'b0000;
        d = done_at.exists(cyc) ? done_at[cyc] : 4'b0000;
        gif.phase_done = d | (4'($urandom) & ~f);
    end
    always @(negedge clk) begin : mon
        exp_t e;
        logic [3:0] ps;
        logic tk;
        if (mon_en) begin
            ps = 4'b0000;
            tk = 1'b0;
            if (exp_q.size() > 0 && exp_q[0].c == cyc) begin
                e = exp_q.pop_front();
                ps = e.ps;
                tk = e.tk;
            end
            chk("phase_start", int'(gif.phase_start), int'(ps));
            chk("game_tick", int'(gif.game_tick), int'(tk));
            chk("busy", int'(gif.busy), int'(busy_at.exists(cyc)));
        end
    end
    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask
    task automatic wait_idle();
        wait_until(be + 7);
    endtask
    task automatic check_counts();
        chk("frame_count", int'(fc), m_frames & 16'hFFFF);
        chk("overrun_count", int'(oc), m_ovr);
        chk("timeout_flag", int'(tf), m_tf);
    endtask
    task automatic frame_evt(input int h);
        px = 10'(H_LAST);
        py = 10'(V_LAST);
        model_trigger(FRAME, cyc + 1);
        repeat (h) @(negedge clk);
        px = '0;
        py = '0;
    endtask
    task automatic press(input bit bounce);
        key = 1'b0;
        if (bounce) begin
            @(negedge clk);
            key = 1'b1;
            @(negedge clk);
            key = 1'b0;
        end
        model_trigger(STEP, cyc + 2 + DEB);
    endtask
    task automatic summary();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    endtask
    initial begin
        #900000;
        n_err++;
        $display("FAIL watchdog: bench did not complete in time");
        summary();
        $finish;
    end
    initial begin
        int m;
        int old_be;
        int extra;
        int n;
        exp_t keep[$];
        rand_dl();
        repeat (3) @(negedge clk);
        chk("reset game_tick", int'(gif.game_tick), 0);
        chk("reset phase_start", int'(gif.phase_start), 0);
        chk("reset busy", int'(gif.busy), 0);
        check_counts();
        rst = 1'b0;
        mon_en = 1'b1;
        // run mode: near-miss positions, then the frame pixel held two cycles
        px = 10'(H_LAST);
        @(negedge clk);
        px = '0;
        py = 10'(V_LAST);
        @(negedge clk);
        py = '0;
        repeat (3) @(negedge clk);
        dl = '{1, 0, 2, 1};
        frame_evt(2);
        wait_idle();
        check_counts();
        // frame events while stalled in PH2 are dropped
        dl = '{0, 0, 14, 0};
        frame_evt(1);
        wait_until(last_e[2]);
        repeat (3) begin
            frame_evt(1);
            repeat (2) @(negedge clk);
        end
        wait_idle();
        check_counts();
        // done on the timeout cycle counts as done; no done at all times out
        dl = '{0, TMO - 1, 0, 0};
        frame_evt(1);
        wait_idle();
        check_counts();
        dl = '{0, -1, 0, 0};
        frame_evt(1);
        wait_idle();
        check_counts();
        // single-step mode: bounced press held 100 cycles, frame events ignored
        sw = 1'b1;
        repeat (6) @(negedge clk);
        model_mode = STEP;
        frame_evt(1);
        repeat (4) @(negedge clk);
        press(1'b1);
        repeat (30) @(negedge clk);
        frame_evt(1);
        repeat (70) @(negedge clk);
        key = 1'b1;
        repeat (DEB + 6) @(negedge clk);
        wait_idle();
        check_counts();
        // mode change mid-sequence only applies once back in IDLE
        dl = '{0, 10, 3, 0};
        press(1'b0);
        wait_until(last_e[1] + 2);
        sw = 1'b0;
        wait_until(last_e[2]);
        frame_evt(1);
        key = 1'b1;
        wait_idle();
        model_mode = FRAME;
        frame_evt(2);
        repeat (3) @(negedge clk);
        press(1'b0);
        repeat (20) @(negedge clk);
        key = 1'b1;
        repeat (DEB + 6) @(negedge clk);
        wait_idle();
        check_counts();
        // randomized run-mode traffic until overrun_count has saturated
        extra = 0;
        n = 0;
        while (n < 2000 && extra < 20) begin
            repeat ($urandom_range(1, 5)) @(negedge clk);
            frame_evt($urandom_range(1, 3));
            if (m_ovr == 255) extra++;
            n++;
        end
        wait_idle();
        check_counts();
        // reset in the middle of PH2
        dl = '{0, 0, 12, 0};
        frame_evt(1);
        wait_until(last_e[2] + 3);
        rst = 1'b1;
        m = cyc;
        old_be = be;
        for (int c = m + 1; c <= old_be; c++) begin
            if (busy_at.exists(c)) busy_at.delete(c);
            if (done_at.exists(c)) done_at.delete(c);
            if (forbid_at.exists(c)) forbid_at.delete(c);
        end
        keep = {};
        foreach (exp_q[i]) if (exp_q[i].c <= m) keep.push_back(exp_q[i]);
        exp_q = keep;
        be = m;
        m_frames = 0;
        m_ovr = 0;
        m_tf = 0;
        @(negedge clk);
        chk("rst busy", int'(gif.busy), 0);
        chk("rst phase_start", int'(gif.phase_start), 0);
        check_counts();
        rst = 1'b0;
        wait_until(old_be + 3);
        frame_evt(1);
        wait_idle();
        check_counts();
        chk("pending expectations", exp_q.size(), 0);
        summary();
        $finish;
    end
endmodule
